// File: rtl/fp16_vector_packer_if.sv
// Handshake bundle between a scalar FP16 producer, the vector packer and the
// downstream vector consumer. The slave modport is the packer's view.
interface fp16_vector_packer_if #(
  parameter int unsigned LENGTH     = 4,
  parameter int unsigned ELEM_WIDTH = 16
) ();
  localparam int unsigned CW = $clog2(LENGTH + 1);

  logic [ELEM_WIDTH-1:0]        in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic                         flush_in;
  logic [LENGTH*ELEM_WIDTH-1:0] out_data;
  logic [CW-1:0]                out_count;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output in_data, in_valid, flush_in, out_ready,
    input  in_ready, out_data, out_count, out_valid
  );

  modport slave (
    input  in_data, in_valid, flush_in, out_ready,
    output in_ready, out_data, out_count, out_valid
  );
endinterface

// File: rtl/fp16_vector_packer.sv
// Packs a scalar FP16 element stream into LENGTH-lane vectors. A fill buffer
// collects lanes; a completed vector either loads straight into the output
// register or, when that is still occupied, waits in the fill buffer (pending).
module fp16_vector_packer #(
  parameter int unsigned LENGTH     = 4,
  parameter int unsigned ELEM_WIDTH = 16
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  debugen_in,
  fp16_vector_packer_if.slave  bus
);
  localparam int unsigned CW = $clog2(LENGTH + 1);
  localparam int unsigned IW = $clog2(LENGTH);
  localparam logic [IW-1:0] LastIdx = IW'(LENGTH - 1);

  typedef logic [LENGTH-1:0][ELEM_WIDTH-1:0] vec_t;

  vec_t          fill_q, fill_d, fill_vec;
  logic [IW-1:0] idx_q, idx_d;
  logic          pending_q, pending_d;
  logic [CW-1:0] pend_count_q, pend_count_d;
  vec_t          out_data_q, out_data_d;
  logic [CW-1:0] out_count_q, out_count_d;
  logic          out_valid_q, out_valid_d;

  logic          accept;
  logic          slot_free;
  logic          complete;
  logic          load;
  logic [CW-1:0] count;

  assign bus.in_ready  = !pending_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_valid = out_valid_q;

  // Next-state: accept into the fill buffer, close vectors, move them to the output.
  always_comb begin
    fill_d       = fill_q;
    idx_d        = idx_q;
    pending_d    = pending_q;
    pend_count_d = pend_count_q;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    out_valid_d  = out_valid_q;
    load         = 1'b0;

    accept    = bus.in_valid && !pending_q;
    slot_free = !out_valid_q || bus.out_ready;

    // Fill contents including this cycle's element, so it can load directly.
    fill_vec = fill_q;
    if (accept) begin
      fill_vec[idx_q] = bus.in_data;
    end
    count    = CW'(idx_q) + CW'(accept);
    complete = !pending_q &&
               ((accept && (idx_q == LastIdx)) ||
                (bus.flush_in && ((idx_q != '0) || accept)));

    if (pending_q) begin
      // Flush is ignored here; the held vector just waits for the output slot.
      if (slot_free) begin
        load        = 1'b1;
        out_data_d  = fill_q;
        out_count_d = pend_count_q;
        fill_d      = '0;
        idx_d       = '0;
        pending_d   = 1'b0;
      end
    end else if (complete) begin
      idx_d = '0;
      if (slot_free) begin
        load        = 1'b1;
        out_data_d  = fill_vec;
        out_count_d = count;
        fill_d      = '0;
      end else begin
        pending_d    = 1'b1;
        fill_d       = fill_vec;
        pend_count_d = count;
      end
    end else if (accept) begin
      fill_d = fill_vec;
      idx_d  = idx_q + IW'(1);
    end

    if (load) begin
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any partial or buffered vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_q       <= '0;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      pend_count_q <= '0;
      out_data_q   <= '0;
      out_count_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      fill_q       <= fill_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      pend_count_q <= pend_count_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      out_valid_q  <= out_valid_d;
    end
  end

`ifndef SYNTHESIS
  // Optional trace of accepted elements and output loads.
  always_ff @(posedge clk) begin
    if (reset && debugen_in) begin
      if (accept) $write("%m: in: %x\n", bus.in_data);
      if (load)   $write("%m: out: %x count %d\n", out_data_d, out_count_d);
    end
  end
`endif
endmodule
